// File: rtl/dcs_cmd_unpacker_pkg.sv
// Shared types and sizing helpers for the DCS command unpacker.
package dcs_cmd_unpacker_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_LOAD  = 4'b0010,
        ST_ISSUE = 4'b0100,
        ST_GAP   = 4'b1000
    } state_t;

    function automatic int pair_bytes(input int addr_w, input int data_w);
        return (addr_w + data_w) / 8;
    endfunction

    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/dcs_cmd_unpacker_fifo.sv
// Pair FIFO with a separate commit pointer: writes stay invisible to the reader until commit.
module dcs_cmd_unpacker_fifo
    import dcs_cmd_unpacker_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     commit,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full
);
    localparam int PTR_W = ptr_width(DEPTH);
    localparam int IDX_W = PTR_W - 1;
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] commit_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign level = commit_ptr - rd_ptr;
    assign full  = (wr_ptr - rd_ptr) == DEPTH_P;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[IDX_W-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            commit_ptr <= '0;
            rd_ptr     <= '0;
            rd_data    <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (commit) begin
                commit_ptr <= wr_ptr;
            end
            if (rd_en) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_data <= mem[rd_ptr[IDX_W-1:0]];
            end
        end
    end

endmodule

// File: rtl/dcs_cmd_unpacker.sv
// Packs the DCS payload byte stream into {addr,data} pairs, buffers them per frame and issues
// them one at a time over a dv/ack handshake with an inter-command gap and an ack timeout.
module dcs_cmd_unpacker
    import dcs_cmd_unpacker_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int CMD_DEPTH   = 16,
    parameter int GAP_CYCLES  = 160,
    parameter int ACK_TIMEOUT = 4096,
    parameter int CNT_W       = 16
) (
    input  logic                         gclk_40m,
    input  logic                         reset_n,
    input  logic                         dcs_rx_dv,
    input  logic [7:0]                   dcs_rxd,
    output logic                         udp_cmd_dv,
    input  logic                         udp_cmd_dv_ack,
    output logic [ADDR_W-1:0]            udp_cmd_addr,
    output logic [DATA_W-1:0]            udp_cmd_data,
    output logic [$clog2(CMD_DEPTH):0]   fifo_level,
    output logic                         err_partial,
    output logic                         err_overflow,
    output logic                         err_timeout,
    output logic [CNT_W-1:0]             cmd_issued_cnt
);
    localparam int PAIR_W  = ADDR_W + DATA_W;
    localparam int PB      = pair_bytes(ADDR_W, DATA_W);
    localparam int BC_W    = $clog2(PB);
    localparam int SH_W    = PAIR_W - 8;
    localparam int TMR_MAX = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [BC_W-1:0]  LAST_BYTE = BC_W'(PB - 1);
    localparam logic [TMR_W-1:0] ACK_LAST  = TMR_W'((ACK_TIMEOUT == 0) ? 0 : ACK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(GAP_CYCLES - 1);

    logic              armed;
    logic              in_frame;
    logic              drop;
    logic [BC_W-1:0]   byte_cnt;
    logic [SH_W-1:0]   shreg;
    logic              byte_ok;
    logic              pair_done;
    logic              frame_end;
    logic              fifo_full;
    logic              wr_en;
    logic              overflow_hit;
    logic [PAIR_W-1:0] rd_pair;

    state_t            state;
    state_t            state_nxt;
    logic [TMR_W-1:0]  timer;
    logic              rd_en;
    logic              ack_hit;
    logic              timeout_hit;

    assign byte_ok      = armed && dcs_rx_dv && !drop;
    assign pair_done    = byte_ok && (byte_cnt == LAST_BYTE);
    assign frame_end    = in_frame && !dcs_rx_dv;
    assign wr_en        = pair_done && !fifo_full;
    assign overflow_hit = pair_done && fifo_full;

    always_ff @(posedge gclk_40m) begin
        if (byte_ok) begin
            shreg <= SH_W'({shreg, dcs_rxd});
        end
    end

    // After reset, a frame already in flight is skipped until dv is seen low once.
    always_ff @(posedge gclk_40m or negedge reset_n) begin
        if (!reset_n) begin
            armed        <= 1'b0;
            in_frame     <= 1'b0;
            drop         <= 1'b0;
            byte_cnt     <= '0;
            err_partial  <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            armed        <= armed || !dcs_rx_dv;
            in_frame     <= armed && dcs_rx_dv;
            err_partial  <= frame_end && (byte_cnt != '0);
            err_overflow <= overflow_hit;
            if (frame_end) begin
                byte_cnt <= '0;
                drop     <= 1'b0;
            end else begin
                if (byte_ok) begin
                    byte_cnt <= pair_done ? '0 : byte_cnt + 1'b1;
                end
                if (overflow_hit) begin
                    drop <= 1'b1;
                end
            end
        end
    end

    dcs_cmd_unpacker_fifo #(
        .WIDTH (PAIR_W),
        .DEPTH (CMD_DEPTH)
    ) u_fifo (
        .clk     (gclk_40m),
        .rst_n   (reset_n),
        .wr_en   (wr_en),
        .wr_data ({shreg, dcs_rxd}),
        .commit  (frame_end),
        .rd_en   (rd_en),
        .rd_data (rd_pair),
        .level   (fifo_level),
        .full    (fifo_full)
    );

    assign udp_cmd_addr = rd_pair[PAIR_W-1 -: ADDR_W];
    assign udp_cmd_data = rd_pair[DATA_W-1:0];
    assign udp_cmd_dv   = (state == ST_ISSUE);

    always_comb begin
        state_nxt   = state;
        rd_en       = 1'b0;
        ack_hit     = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            ST_IDLE: begin
                if (fifo_level != '0) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                rd_en     = 1'b1;
                state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (udp_cmd_dv_ack) begin
                    ack_hit   = 1'b1;
                    state_nxt = ST_GAP;
                end else if ((ACK_TIMEOUT != 0) && (timer == ACK_LAST)) begin
                    timeout_hit = 1'b1;
                    state_nxt   = ST_GAP;
                end
            end
            ST_GAP: begin
                if (timer == GAP_LAST) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // The timer restarts on every state change, so it counts clocks spent in the current state.
    always_ff @(posedge gclk_40m or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            timer          <= '0;
            err_timeout    <= 1'b0;
            cmd_issued_cnt <= '0;
        end else begin
            state       <= state_nxt;
            timer       <= (state_nxt != state) ? '0 : timer + 1'b1;
            err_timeout <= timeout_hit;
            if (ack_hit) begin
                cmd_issued_cnt <= cmd_issued_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dcs_cmd_unpacker.sv
// Directed bench for dcs_cmd_unpacker: table of frames plus back-to-back and reset sequences.
module tb_dcs_cmd_unpacker;
    localparam int GAP = 6;
    localparam int TO  = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        dcs_rx_dv;
    logic [7:0]  dcs_rxd;
    logic        udp_cmd_dv;
    logic        ack;
    logic [31:0] udp_cmd_addr;
    logic [31:0] udp_cmd_data;
    logic [2:0]  fifo_level;
    logic        err_partial;
    logic        err_overflow;
    logic        err_timeout;
    logic [15:0] cmd_issued_cnt;

    dcs_cmd_unpacker #(
        .ADDR_W(32), .DATA_W(32), .CMD_DEPTH(4), .GAP_CYCLES(GAP), .ACK_TIMEOUT(TO), .CNT_W(16)
    ) dut (
        .gclk_40m       (clk),
        .reset_n        (reset_n),
        .dcs_rx_dv      (dcs_rx_dv),
        .dcs_rxd        (dcs_rxd),
        .udp_cmd_dv     (udp_cmd_dv),
        .udp_cmd_dv_ack (ack),
        .udp_cmd_addr   (udp_cmd_addr),
        .udp_cmd_data   (udp_cmd_data),
        .fifo_level     (fifo_level),
        .err_partial    (err_partial),
        .err_overflow   (err_overflow),
        .err_timeout    (err_timeout),
        .cmd_issued_cnt (cmd_issued_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int checks = 0;
    int failures = 0;
    int exp_cnt = 0;
    int ack_mode = 0;

    // Monitor state
    int          rise_q[$];
    int          fall_q[$];
    int          hi_q[$];
    int          lvl_q[$];
    logic [31:0] a_q[$];
    logic [31:0] d_q[$];
    int          hi_run = 0;
    int          n_part = 0;
    int          n_ovf = 0;
    int          n_to = 0;
    int          n_ack = 0;
    logic        dv_prev = 1'b0;
    int          lvl_prev = 0;

    logic [31:0] exp_a[$];
    logic [31:0] exp_d[$];

    typedef struct {
        string       name;
        logic [31:0] ba;
        logic [31:0] bd;
        int          npairs;
        int          extra;
        int          mode;
        int          exp_cmds;
        int          exp_hi;
        int          exp_part;
        int          exp_ovf;
        int          exp_to;
    } row_t;
    row_t rows[6];

    // Consumer model and monitor; ack modes: 0 never, 1 immediate, 2 after 2 clks, 3 held high.
    always @(negedge clk) begin
        if (udp_cmd_dv && !dv_prev) begin
            rise_q.push_back(cyc);
            a_q.push_back(udp_cmd_addr);
            d_q.push_back(udp_cmd_data);
            lvl_q.push_back(lvl_prev);
            hi_run = 0;
        end
        if (!udp_cmd_dv && dv_prev) begin
            fall_q.push_back(cyc);
            hi_q.push_back(hi_run);
        end
        case (ack_mode)
            1:       ack = udp_cmd_dv;
            2:       ack = udp_cmd_dv && (hi_run == 2);
            3:       ack = 1'b1;
            default: ack = 1'b0;
        endcase
        if (udp_cmd_dv) begin
            if (ack) n_ack = n_ack + 1;
            hi_run = hi_run + 1;
        end
        n_part   = n_part + int'(err_partial);
        n_ovf    = n_ovf + int'(err_overflow);
        n_to     = n_to + int'(err_timeout);
        dv_prev  = udp_cmd_dv;
        lvl_prev = int'(fifo_level);
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks = checks + 1;
        if (act != exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clr_mon();
        rise_q.delete(); fall_q.delete(); hi_q.delete(); lvl_q.delete();
        a_q.delete(); d_q.delete();
        n_part = 0; n_ovf = 0; n_to = 0; n_ack = 0;
        exp_a.delete(); exp_d.delete();
    endtask

    task automatic drive_byte(input logic [7:0] b);
        @(posedge clk); #1;
        dcs_rx_dv = 1'b1;
        dcs_rxd   = b;
    endtask

    task automatic end_frame(output int fe);
        @(posedge clk); #1;
        dcs_rx_dv = 1'b0;
        dcs_rxd   = 8'h00;
        fe        = cyc;
    endtask

    task automatic send_pairs(input logic [31:0] ba, input logic [31:0] bd, input int n, input int extra);
        for (int k = 0; k < n; k++) begin
            logic [63:0] p;
            p = {ba + 32'(k), bd + 32'(k)};
            for (int j = 0; j < 8; j++) drive_byte(p[63 - 8*j -: 8]);
        end
        for (int j = 0; j < extra; j++) drive_byte(8'hA5 + 8'(j));
    endtask

    task automatic expect_pairs(input logic [31:0] ba, input logic [31:0] bd, input int n);
        for (int k = 0; k < n; k++) begin
            exp_a.push_back(ba + 32'(k));
            exp_d.push_back(bd + 32'(k));
        end
    endtask

    task automatic verify(input string tag, input int fe, input int hi, input int part,
                          input int ovf, input int to, input bit chk_lvl);
        int n;
        n = exp_a.size();
        repeat (40 + 20 * n) @(posedge clk);
        @(negedge clk);
        exp_cnt = exp_cnt + (n - to);
        chk({tag, "_ncmd"}, rise_q.size(), n);
        for (int k = 0; k < n && k < rise_q.size(); k++) begin
            chk($sformatf("%s_addr%0d", tag, k), a_q[k], exp_a[k]);
            chk($sformatf("%s_data%0d", tag, k), d_q[k], exp_d[k]);
            chk($sformatf("%s_dvlen%0d", tag, k), (k < hi_q.size()) ? hi_q[k] : -1, hi);
            if (chk_lvl) chk($sformatf("%s_level%0d", tag, k), lvl_q[k], n - k);
            if (k == 0) chk({tag, "_latency"}, rise_q[0] - fe, 3);
            else chk($sformatf("%s_gap%0d", tag, k), rise_q[k] - fall_q[k-1], GAP + 2);
        end
        chk({tag, "_partial"}, n_part, part);
        chk({tag, "_overflow"}, n_ovf, ovf);
        chk({tag, "_timeout"}, n_to, to);
        chk({tag, "_acks"}, n_ack, n - to);
        chk({tag, "_cnt"}, cmd_issued_cnt, exp_cnt);
        chk({tag, "_drained"}, {udp_cmd_dv, fifo_level}, 0);
    endtask

    int fe;
    int fe2;

    initial begin
        rows[0] = '{"t1_single",   32'h10, 32'hDEADBEEF, 1, 0, 2, 1, 3, 0, 0, 0};
        rows[1] = '{"t2_three",    32'h20, 32'h11110000, 3, 0, 1, 3, 1, 0, 0, 0};
        rows[2] = '{"t3_partial",  32'h30, 32'h22220000, 1, 3, 1, 1, 1, 1, 0, 0};
        rows[3] = '{"t4_overflow", 32'h40, 32'h33330000, 6, 0, 1, 4, 1, 0, 1, 0};
        rows[4] = '{"t5_timeout",  32'h50, 32'h44440000, 2, 0, 0, 2, TO, 0, 0, 2};
        rows[5] = '{"ack_held",    32'h60, 32'h55550000, 2, 0, 3, 2, 1, 0, 0, 0};

        reset_n   = 1'b0;
        dcs_rx_dv = 1'b0;
        dcs_rxd   = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_addr", udp_cmd_addr, 0);
        chk("reset_data", udp_cmd_data, 0);
        chk("reset_ctl", {udp_cmd_dv, fifo_level, err_partial, err_overflow, err_timeout, cmd_issued_cnt}, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int r = 0; r < 6; r++) begin
            clr_mon();
            ack_mode = rows[r].mode;
            expect_pairs(rows[r].ba, rows[r].bd, rows[r].exp_cmds);
            send_pairs(rows[r].ba, rows[r].bd, rows[r].npairs, rows[r].extra);
            end_frame(fe);
            verify(rows[r].name, fe, rows[r].exp_hi, rows[r].exp_part, rows[r].exp_ovf, rows[r].exp_to, 1'b1);
        end

        // Second frame arrives while the first is still being issued.
        clr_mon();
        ack_mode = 1;
        expect_pairs(32'h100, 32'hA0000000, 2);
        expect_pairs(32'h200, 32'hB0000000, 1);
        send_pairs(32'h100, 32'hA0000000, 2, 0);
        end_frame(fe);
        send_pairs(32'h200, 32'hB0000000, 1, 0);
        end_frame(fe2);
        verify("b2b", fe, 1, 0, 0, 0, 1'b0);

        // Reset mid-frame; the frame still running at release must be ignored.
        clr_mon();
        ack_mode = 1;
        expect_pairs(32'h400, 32'hC0000000, 1);
        for (int j = 0; j < 5; j++) drive_byte(8'h30 + 8'(j));
        for (int i = 0; i < 3; i++) begin
            drive_byte(8'h5A);
            reset_n = 1'b0;
            @(negedge clk);
            chk("rst_addr", udp_cmd_addr, 0);
            chk("rst_data", udp_cmd_data, 0);
            chk("rst_ctl", {udp_cmd_dv, fifo_level, err_partial, err_overflow, err_timeout, cmd_issued_cnt}, 0);
        end
        drive_byte(8'h5A);
        reset_n = 1'b1;
        for (int j = 0; j < 8; j++) drive_byte(8'h77);
        end_frame(fe);
        exp_cnt = 0;
        send_pairs(32'h400, 32'hC0000000, 1, 0);
        end_frame(fe);
        verify("t6_reset", fe, 1, 0, 0, 0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
